uart_transmitter: RTL
=====================

UART_TRANSMITTER -- requirements
Module: uart_transmitter

Interface
REQ-001 Parameter CPB, default 434, SHALL set clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 clk  input  1  system clock, 50 MHz; all state SHALL update on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-low: sampled on the rising edge of clk, asserted when 0.
REQ-004 valid  input  1  SHALL indicate that data holds a byte to send.
REQ-005 data  input  8  SHALL carry the byte to send, sampled only on acceptance.
REQ-006 ready  output  1  SHALL indicate the block can accept a byte this cycle.
REQ-007 busy  output  1  SHALL be high while a frame is on the line.
REQ-008 tx  output  1  SHALL be the serial line output, idle high.

Function
REQ-009 States SHALL be IDLE, START, DATA_BITS, PARITY (present only with the macro in REQ-025) and STOP.
REQ-010 ready SHALL be 1 only in IDLE; busy SHALL be the inverse of ready.
REQ-011 Acceptance SHALL occur on a rising edge with valid=1 and ready=1; data SHALL be latched into an internal shift register on that edge.
REQ-012 On acceptance the state SHALL go IDLE->START; tx SHALL be 0 from the cycle after acceptance (1-cycle latency).
REQ-013 Every bit period SHALL hold tx stable for exactly CPB cycles, timed by a down/up counter of width clog2(CPB), which resets to 0 at each bit boundary.
REQ-014 START SHALL drive tx=0 for CPB cycles and then enter DATA_BITS with bit index 0.
REQ-015 DATA_BITS SHALL send 8 bits LSB first, each for CPB cycles; after bit 7 the state SHALL go to PARITY if compiled in, otherwise to STOP.
REQ-016 STOP SHALL drive tx=1 for CPB cycles and then return to IDLE.
REQ-017 A full frame SHALL occupy exactly 10*CPB cycles, or 11*CPB with parity, from the first tx=0 cycle to the last stop cycle.
REQ-018 valid held high continuously SHALL yield back-to-back frames separated by exactly one IDLE cycle (tx=1).
REQ-019 Changes on valid or data while busy=1 SHALL be ignored and SHALL NOT corrupt the frame in flight.
REQ-020 The bit index SHALL NOT wrap: the counter and index SHALL be cleared on every entry to IDLE.
REQ-021 An illegal or unused state encoding SHALL return to IDLE on the next edge with tx=1.

Reset
REQ-022 While rst=0 at a rising edge, the block SHALL set state=IDLE, tx=1, ready=1, busy=0, and clear the counter, the bit index and the shift register.
REQ-023 Reset asserted mid-frame SHALL abort the frame; tx SHALL be 1 from the next cycle, and no partial frame SHALL resume after reset is released.
REQ-024 valid asserted in the same cycle that rst=0 SHALL NOT be accepted.

Configuration
REQ-025 Macro UART_TX_PARITY_EN defined: the PARITY state SHALL be compiled in, sending one even-parity bit (XOR of the 8 data bits) for CPB cycles between bit 7 and STOP.
REQ-026 Macro UART_TX_PARITY_EN undefined: the PARITY state and its logic SHALL be absent, and the frame SHALL be 8N1.

Structure
REQ-027 Shared package uart_pkg SHALL hold the state encoding constants, the default CPB (434), the data width (8) and the frame bit counts; the existing receiver is to share it.
REQ-028 Baud timing SHALL be factored into one sub-module, uart_baud_gen, which produces a one-cycle bit_done pulse every CPB cycles while enabled and clears when disabled.

Verification (bench uses CPB=4 unless noted)
REQ-029 Reset, then valid=1 with data=0x55 -> tx holds 0 for 4 cycles, then the bits 1,0,1,0,1,0,1,0 for 4 cycles each, then 1 for 4 cycles; ready returns to 1 at cycle 41 after acceptance.
REQ-030 valid held high with data=0xA3 then 0x0F -> two frames, with exactly one tx=1 IDLE cycle between the stop bit of the first and the start bit of the second.
REQ-031 data changed to 0xFF during the frame for 0x00 -> all 8 data bits are sent as 0.
REQ-032 rst=0 for one cycle during bit 3 of a frame -> tx=1, ready=1 next cycle; line stays 1 until the next valid.
REQ-033 UART_TX_PARITY_EN defined, data=0x07 -> parity bit 1 after bit 7; frame length 44 cycles.
REQ-034 Loopback at CPB=434: tx connected to the existing receiver's rx, bytes 0x00, 0xFF, 0x5A -> the receiver reports valid with matching data for each byte.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, default bit timing, data width and
// frame bit counts. Imported by the transmitter, its baud generator and the
// receiver so both ends agree on framing.
package uart_pkg;

  // 50 MHz system clock / 115200 baud
  localparam int unsigned CPB_DEFAULT = 434;

  localparam int unsigned DATA_W      = 8;
  localparam int unsigned IDX_W       = $clog2(DATA_W);
  localparam int unsigned START_BITS  = 1;
  localparam int unsigned STOP_BITS   = 1;
  localparam int unsigned PARITY_BITS = 1;

  // Bits on the line per frame: 8N1 and 8E1
  localparam int unsigned FRAME_BITS_NOPAR = START_BITS + DATA_W + STOP_BITS;
  localparam int unsigned FRAME_BITS_PAR   = FRAME_BITS_NOPAR + PARITY_BITS;

  // Index of the last data bit, used to leave the data phase
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_e;

  // Even parity: the parity bit makes the total count of ones even
  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: one-cycle bit_done pulse every CPB cycles while en is high.
// Latency: first pulse on the CPB-th enabled cycle; counter clears when en is low or clr is high.
// Backpressure: none, free-running while enabled.
// Ports: clk, rst (sync, active-low), en (count enable), clr (force counter to 0),
//        bit_done (last cycle of the current bit period).
module uart_baud_gen
  import uart_pkg::*;
#(
  parameter int unsigned CPB = CPB_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic clr,
  output logic bit_done
);

  localparam int unsigned      CW   = (CPB > 1) ? $clog2(CPB) : 1;
  localparam logic [CW-1:0]    LAST = CW'(CPB - 1);

  logic [CW-1:0] cnt;

  assign bit_done = en && (cnt == LAST);

  // Counter restarts from 0 at every bit boundary so each bit lasts exactly CPB cycles
  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt <= '0;
    end else if (!en || clr || bit_done) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/uart_transmitter.sv
// UART transmitter: serialises one byte per frame, start bit, 8 data bits LSB first,
// optional even parity (UART_TX_PARITY_EN), one stop bit; each bit held CPB cycles.
// Latency: tx goes low the cycle after acceptance; ready returns one cycle after the stop bit.
// Backpressure: ready is high only in IDLE; valid/data are ignored while busy.
// Ports: clk, rst (sync, active-low), valid/data (byte in), ready, busy, tx (serial line, idle high).
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int unsigned CPB = CPB_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid,
  input  logic [DATA_W-1:0] data,
  output logic              ready,
  output logic              busy,
  output logic              tx
);

  uart_state_e        state;
  uart_state_e        state_next;
  logic [DATA_W-1:0]  shreg;
  logic [IDX_W-1:0]   bit_idx;
  logic               bit_done;
  logic               baud_en;
  logic               baud_clr;
`ifdef UART_TX_PARITY_EN
  logic               par_q;
`endif

  // Counter runs in every non-idle state and is forced clear on any entry to IDLE,
  // including recovery from an illegal encoding.
  assign baud_en  = (state != ST_IDLE);
  assign baud_clr = (state_next == ST_IDLE);

  uart_baud_gen #(
    .CPB(CPB)
  ) u_baud_gen (
    .clk      (clk),
    .rst      (rst),
    .en       (baud_en),
    .clr      (baud_clr),
    .bit_done (bit_done)
  );

  // Next-state and line decode
  always_comb begin
    state_next = state;
    tx         = 1'b1;
    ready      = 1'b0;
    case (state)
      ST_IDLE: begin
        ready = 1'b1;
        if (valid) state_next = ST_START;
      end
      ST_START: begin
        tx = 1'b0;
        if (bit_done) state_next = ST_DATA;
      end
      ST_DATA: begin
        tx = shreg[0];
        if (bit_done && (bit_idx == IDX_LAST)) begin
`ifdef UART_TX_PARITY_EN
          state_next = ST_PARITY;
`else
          state_next = ST_STOP;
`endif
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        tx = par_q;
        if (bit_done) state_next = ST_STOP;
      end
`endif
      ST_STOP: begin
        tx = 1'b1;
        if (bit_done) state_next = ST_IDLE;
      end
      default: begin
        // Unused encodings fall back to an idle line
        tx         = 1'b1;
        state_next = ST_IDLE;
      end
    endcase
  end

  assign busy = ~ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= ST_IDLE;
      shreg   <= '0;
      bit_idx <= '0;
`ifdef UART_TX_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state <= state_next;
      case (state)
        ST_IDLE: begin
          if (valid) begin
            shreg <= data;
`ifdef UART_TX_PARITY_EN
            par_q <= even_parity(data);
`endif
          end
        end
        ST_START: begin
          bit_idx <= '0;
        end
        ST_DATA: begin
          if (bit_done) begin
            shreg <= {1'b0, shreg[DATA_W-1:1]};
            // Hold at the last index rather than wrapping back to 0
            if (bit_idx != IDX_LAST) bit_idx <= bit_idx + IDX_W'(1);
          end
        end
        default: begin
        end
      endcase
      if (state_next == ST_IDLE) bit_idx <= '0;
    end
  end

endmodule
